// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU, the unified
// memory port and the register file through fetch/decode/execute/memory/writeback.
module multicycle_control #(
  parameter bit RESET_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] Op,
  input  logic [2:0] F3,
  input  logic       F7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       retired,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StLui,
    StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARegA  = 2'b10;
  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;
  localparam logic [1:0] ResImm    = 2'b11;

  localparam state_e ResetState = RESET_FETCH ? StFetch : StIdle;

  state_e     state_q, state_d;
  logic       f3_bad;
  logic       funct_bad;
  logic [2:0] alu_funct;
  logic [2:0] imm_dec;

  // Shift and unsigned-compare encodings are outside the supported subset.
  assign f3_bad = (F3 == 3'b001) || (F3 == 3'b011) || (F3 == 3'b101);

  always_comb begin
    funct_bad = 1'b0;
    case (Op)
      OpR:      funct_bad = f3_bad || (F7b5 && (F3 != 3'b000));
      OpI:      funct_bad = f3_bad;
      OpBranch: funct_bad = (F3[2:1] != 2'b00);
      default:  funct_bad = 1'b0;
    endcase
  end

  always_comb begin
    alu_funct = AluAdd;
    case (F3)
      3'b000:  alu_funct = ((Op == OpR) && F7b5) ? AluSub : AluAdd;
      3'b111:  alu_funct = AluAnd;
      3'b110:  alu_funct = AluOr;
      3'b100:  alu_funct = AluXor;
      3'b010:  alu_funct = AluSlt;
      default: alu_funct = AluAdd;
    endcase
  end

  always_comb begin
    imm_dec = 3'b000;
    case (Op)
      OpLoad, OpI: imm_dec = 3'b000;
      OpStore:     imm_dec = 3'b001;
      OpBranch:    imm_dec = 3'b010;
      OpLui:       imm_dec = 3'b011;
      OpJal:       imm_dec = 3'b100;
      default:     imm_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start) state_d = StFetch;
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (funct_bad) begin
          state_d = StTrap;
        end else begin
          case (Op)
            OpLoad, OpStore: state_d = StMemAdr;
            OpR:             state_d = StExecR;
            OpI:             state_d = StExecI;
            OpBranch:        state_d = StBranch;
            OpJal:           state_d = StJal;
            OpLui:           state_d = StLui;
            default:         state_d = StTrap;
          endcase
        end
      end
      StMemAdr:   state_d = Op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR,
      StExecI,
      StJal:      state_d = StAluWb;
      StMemWb,
      StAluWb,
      StBranch,
      StLui:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ResetState;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low while rst is high so an aborted access drops at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRegB;
    alu_ctrl   = AluAdd;
    result_src = ResAluOut;
    imm_src    = 3'b000;
    retired    = 1'b0;
    illegal    = 1'b0;
    if (!rst && (state_q != StIdle)) begin
      imm_src = imm_dec;
      case (state_q)
        StFetch: begin
          mem_req    = 1'b1;
          alu_src_a  = SrcAPc;
          alu_src_b  = SrcBFour;
          result_src = ResAlu;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        StDecode: begin
          alu_src_a = SrcAOldPc;
          alu_src_b = SrcBImm;
        end
        StMemAdr: begin
          alu_src_a = SrcARegA;
          alu_src_b = SrcBImm;
        end
        StMemRead: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        StMemWb: begin
          result_src = ResMem;
          reg_write  = 1'b1;
          retired    = 1'b1;
        end
        StMemWrite: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          retired = mem_ready;
        end
        StExecR: begin
          alu_src_a = SrcARegA;
          alu_src_b = SrcBRegB;
          alu_ctrl  = alu_funct;
        end
        StExecI: begin
          alu_src_a = SrcARegA;
          alu_src_b = SrcBImm;
          alu_ctrl  = alu_funct;
        end
        StAluWb: begin
          result_src = ResAluOut;
          reg_write  = 1'b1;
          retired    = 1'b1;
        end
        StBranch: begin
          alu_src_a  = SrcARegA;
          alu_src_b  = SrcBRegB;
          alu_ctrl   = AluSub;
          result_src = ResAluOut;
          retired    = 1'b1;
          pc_write   = ((F3 == 3'b000) && zero) || ((F3 == 3'b001) && !zero);
        end
        StJal: begin
          alu_src_a  = SrcAOldPc;
          alu_src_b  = SrcBFour;
          result_src = ResAluOut;
          pc_write   = 1'b1;
        end
        StLui: begin
          result_src = ResImm;
          reg_write  = 1'b1;
          retired    = 1'b1;
        end
        StTrap:  illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its expected
// per-cycle output vectors from the instruction-class rules and compared every cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic       clk, rst, start, F7b5, zero, mem_ready;
  logic [6:0] Op;
  logic [2:0] F3;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, retired, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_ctrl, imm_src;

  multicycle_control #(.RESET_FETCH(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .Op(Op), .F3(F3), .F7b5(F7b5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .imm_src(imm_src), .retired(retired), .illegal(illegal)
  );

  typedef enum {SFetch, SDecode, SAddr, SRead, SLoadWb, SWrite, SExec, SAluWb,
                SBranch, SJal, SLui, STrap, SOff} step_e;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;

  int n_vec = 0;
  int n_fail = 0;
  int force_zero = -1;

  logic [19:0] dut_vec;
  assign dut_vec = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                    alu_src_b, alu_ctrl, result_src, imm_src, retired, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %05h want %05h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == LW || op == IT) return 3'b000;
    if (op == SW) return 3'b001;
    if (op == BR) return 3'b010;
    if (op == LUI) return 3'b011;
    if (op == JAL) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bit f3bad;
    f3bad = (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b101);
    if (op == LW || op == SW || op == LUI || op == JAL) return 1'b1;
    if (op == RT) return !f3bad && !(f7 && f3 != 3'b000);
    if (op == IT) return !f3bad;
    if (op == BR) return f3 == 3'b000 || f3 == 3'b001;
    return 1'b0;
  endfunction

  function automatic logic [19:0] exp_vec(input step_e s, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic mr);
    logic mreq = 0, mwe = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ret = 0, ill = 0;
    logic [1:0] a = 0, b = 0, rs = 0;
    logic [2:0] ctl = 0, imm;
    imm = imm_of(op);
    case (s)
      SFetch:  begin mreq = 1; b = 2; rs = 2; irw = mr; pcw = mr; end
      SDecode: begin a = 1; b = 1; end
      SAddr:   begin a = 2; b = 1; end
      SRead:   begin mreq = 1; adr = 1; end
      SLoadWb: begin rs = 1; rw = 1; ret = 1; end
      SWrite:  begin mreq = 1; mwe = 1; adr = 1; ret = mr; end
      SExec:   begin a = 2; b = (op == RT) ? 2'd0 : 2'd1; ctl = alu_of(op, f3, f7); end
      SAluWb:  begin rw = 1; ret = 1; end
      SBranch: begin a = 2; ctl = 1; ret = 1; pcw = (f3 == 3'b000) ? z : !z; end
      SJal:    begin a = 1; b = 2; pcw = 1; end
      SLui:    begin rs = 3; rw = 1; ret = 1; end
      STrap:   ill = 1;
      default: imm = 3'b000;
    endcase
    return {mreq, mwe, adr, irw, pcw, rw, a, b, ctl, rs, imm, ret, ill};
  endfunction

  task automatic do_cycle(input step_e s, input bit ld, input logic [6:0] op,
                          input logic [2:0] f3, input logic f7, input bit mr);
    @(negedge clk);
    rst = 1'b0;
    if (ld) begin Op = op; F3 = f3; F7b5 = f7; end
    mem_ready = mr;
    zero = (force_zero < 0) ? 1'($urandom_range(0, 1)) : 1'(force_zero);
    #1 check_vec(s.name(), dut_vec, exp_vec(s, Op, F3, F7b5, zero, mr));
  endtask

  // Called just after a check, mid low phase; holds rst across one rising edge.
  task automatic hold_reset(input string tag);
    rst = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    #1 check_vec({tag, "_async"}, dut_vec, exp_vec(SOff, Op, F3, F7b5, zero, mem_ready));
    @(posedge clk);
    #1 check_vec({tag, "_held"}, dut_vec, exp_vec(SOff, Op, F3, F7b5, zero, mem_ready));
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int rd_waits, input bit abort_wr);
    step_e q[$];
    bit    first, done, mr, is_mem;
    int    waits;
    q.push_back(SFetch);
    q.push_back(SDecode);
    if (!legal(op, f3, f7)) begin
      for (int i = 0; i < 20; i++) q.push_back(STrap);
    end else if (op == LW) begin
      q.push_back(SAddr); q.push_back(SRead); q.push_back(SLoadWb);
    end else if (op == SW) begin
      q.push_back(SAddr); q.push_back(SWrite);
    end else if (op == RT || op == IT) begin
      q.push_back(SExec); q.push_back(SAluWb);
    end else if (op == BR) begin
      q.push_back(SBranch);
    end else if (op == JAL) begin
      q.push_back(SJal); q.push_back(SAluWb);
    end else begin
      q.push_back(SLui);
    end
    first = 1'b1;
    foreach (q[i]) begin
      waits = 0;
      done  = 1'b0;
      is_mem = (q[i] == SFetch) || (q[i] == SRead) || (q[i] == SWrite);
      while (!done) begin
        if (!is_mem) mr = 1'($urandom_range(0, 1));
        else if (q[i] == SRead && rd_waits >= 0) mr = (waits >= rd_waits);
        else if (q[i] == SWrite && abort_wr) mr = 1'b0;
        else mr = (waits >= 3) || ($urandom_range(0, 3) != 0);
        do_cycle(q[i], first, op, f3, f7, mr);
        first = 1'b0;
        if (q[i] == SWrite && abort_wr) begin
          hold_reset("rst_in_write");
          return;
        end
        done = !is_mem || mr;
        waits++;
      end
    end
    if (!legal(op, f3, f7)) hold_reset("rst_after_trap");
  endtask

  task automatic run_random();
    logic [2:0] legal_f3 [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    logic [2:0] f3;
    int k;
    k = $urandom_range(0, 11);
    f3 = legal_f3[$urandom_range(0, 4)];
    case (k)
      0, 1:    run_instr(LW, 3'b010, 1'b0, -1, 1'b0);
      2:       run_instr(SW, 3'b010, 1'b0, -1, 1'b0);
      3, 4:    run_instr(RT, f3, (f3 == 3'b000) ? 1'($urandom_range(0, 1)) : 1'b0, -1, 1'b0);
      5, 6:    run_instr(IT, f3, 1'($urandom_range(0, 1)), -1, 1'b0);
      7, 8:    run_instr(BR, 3'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
      9:       run_instr(JAL, 3'($urandom), 1'($urandom), -1, 1'b0);
      10:      run_instr(LUI, 3'($urandom), 1'($urandom), -1, 1'b0);
      default: run_instr(7'($urandom), 3'($urandom), 1'($urandom), -1, 1'b0);
    endcase
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; Op = '0; F3 = '0; F7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    #1 check_vec("reset", dut_vec, exp_vec(SOff, Op, F3, F7b5, zero, mem_ready));
    run_instr(RT, 3'b000, 1'b1, 0, 1'b0);            // sub
    run_instr(LW, 3'b010, 1'b0, 2, 1'b0);            // two wait cycles in MEMREAD
    force_zero = 1; run_instr(BR, 3'b000, 1'b0, -1, 1'b0);
    force_zero = 0; run_instr(BR, 3'b000, 1'b0, -1, 1'b0);
    force_zero = 0; run_instr(BR, 3'b001, 1'b0, -1, 1'b0);
    force_zero = -1;
    run_instr(JAL, 3'b000, 1'b0, -1, 1'b0);
    run_instr(IT, 3'b001, 1'b0, -1, 1'b0);           // slli traps
    run_instr(7'b0000000, 3'b000, 1'b0, -1, 1'b0);
    run_instr(RT, 3'b111, 1'b1, -1, 1'b0);           // bad F7b5 traps
    run_instr(SW, 3'b010, 1'b0, -1, 1'b1);           // reset during stalled store
    run_instr(LUI, 3'b000, 1'b0, -1, 1'b0);
    for (int n = 0; n < 200; n++) run_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core. Sequences one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback steps.
- Consumes the decoded fields from the instruction decoder: Op, F3, and F7 bit 5.
- Drives every datapath mux select, write enable and the ALU operation.
- Supported instruction subset: lw, sw, R-type ALU, I-type ALU, beq/bne, lui, jal. Any other encoding traps.

Parameters:
- RESET_FETCH, 1, when 1 the FSM leaves reset directly into FETCH. When 0 it waits for a one-cycle start pulse.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin execution; used only when RESET_FETCH=0
- Op  input  7  opcode from decoder
- F3  input  3  funct3 from decoder
- F7b5  input  1  instr[30]
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory completes the access this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  memory write
- adr_src  output  1  0 = PC, 1 = ALUOut
- ir_write  output  1  latch instruction register and OldPC
- pc_write  output  1  load PC from result bus
- reg_write  output  1  register file write
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1 register A
- alu_src_b  output  2  00 = rs2 register B, 01 = ImmExt, 10 = constant 4
- alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- result_src  output  2  00 = ALUOut, 01 = mem data, 10 = ALU result, 11 = ImmExt
- imm_src  output  3  000 I, 001 S, 010 B, 011 U, 100 J
- retired  output  1  one-cycle pulse in the final cycle of each instruction
- illegal  output  1  sticky trap flag

Behaviour:
Reset and idle:
- Asynchronous reset sets state to FETCH (RESET_FETCH=1) or IDLE (RESET_FETCH=0) and clears illegal.
- While rst is high, every output is 0.
- IDLE: all outputs 0. Moves to FETCH on start.

Output timing and immediate select:
- Outputs are combinational (Moore) from state, plus Op/F3/F7b5/zero where noted.
- State updates on the rising edge.
- imm_src is decoded from Op in every state: 0000011/0010011 -> I, 0100011 -> S, 1100011 -> B, 0110111 -> U, 1101111 -> J, else 000.

States (outputs not listed are 0):
- FETCH: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10. ir_write and pc_write equal mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: a=01, b=01, add (branch/jump target is captured into ALUOut). Next state by Op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else, or an illegal funct (below) -> TRAP
- MEMADR: a=10, b=01, add. Goes to MEMREAD if Op[5]=0, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, retired=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Holds until mem_ready. In the mem_ready cycle retired=1, then goes to FETCH.
- EXECR / EXECI: a=10, b=00 (EXECR) or 01 (EXECI), alu_ctrl from the funct decode below. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, retired=1. Goes to FETCH.
- BRANCH: a=10, b=00, sub, result_src=00, retired=1. pc_write = (F3==000 & zero) | (F3==001 & ~zero). Goes to FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1. Goes to ALUWB, which writes OldPC+4 to rd.
- LUI: result_src=11, reg_write=1, retired=1. Goes to FETCH.
- TRAP: illegal=1, all enables 0. Terminal until reset.

Funct decode:
- F3 mapping: 000 -> add (sub if R-type and F7b5=1), 111 -> and, 110 -> or, 100 -> xor, 010 -> slt.
- Illegal: F3 in {001, 011, 101}; R-type with F7b5=1 and F3!=000; branch with F3 other than 000/001.

Latency with mem_ready tied high:
- lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq/bne and lui 3 cycles.
- Each mem_ready=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_req stays high and all address/select outputs stay stable while waiting.

Boundary conditions:
- rst asserted mid-instruction aborts the instruction immediately. No write enable may be asserted in the reset cycle or the following cycle unless state is FETCH with mem_ready.
- retired is never asserted in TRAP or IDLE.

Test Plan:
- Reset release, Op=0110011 F3=000 F7b5=1, mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_ctrl=001 in EXECR; reg_write and retired high in cycle 4 only.
- lw (Op=0000011) with mem_ready low for 2 cycles in MEMREAD -> mem_req=1, adr_src=1 held for 3 cycles; MEMWB on the 7th cycle with result_src=01 and reg_write=1.
- beq (Op=1100011 F3=000) zero=1 then zero=0 -> pc_write=1 in the BRANCH cycle for the first, 0 for the second; both pulse retired; 3 cycles each.
- jal (Op=1101111) -> JAL cycle pc_write=1, a=01, b=10; next cycle ALUWB reg_write=1; imm_src=100 throughout.
- Op=0010011 F3=001 (slli) and Op=0000000 -> TRAP after DECODE; illegal=1 sticky for 20 cycles; all enables 0; cleared by rst.
- rst asserted in MEMWRITE while mem_ready=0 -> mem_we drops asynchronously; after release, state is FETCH and no memory write occurs.
